// File: rtl/exp_range_reduce.sv
// exp_range_reduce: splits an unsigned fixed-point argument into x = k*LN2 + r
// (0 <= r < LN2) by repeated subtraction, one compare per cycle. It produces k,
// the remainder, a LUT index taken from the top fraction bits of r, the
// int/fraction path flag and a saturation flag. Only one operation is in
// flight at a time.
module exp_range_reduce #(
  parameter int DATA_W = 15,
  parameter int FRAC_W = 11,
  parameter int LN2    = 1419,
  parameter int K_W    = 5,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K_W-1:0]    out_k,
  output logic [DATA_W-1:0] out_rem,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_int_or_fra,
  output logic              out_ovf
);

  localparam logic [DATA_W-1:0] LN2_V = DATA_W'(LN2);
  localparam logic [K_W-1:0]    K_MAX = '1;

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rem;
  logic [K_W-1:0]    k;
  logic              rem_ge;
  logic              k_sat;

  // Full-width compare, so the subtraction below can never underflow.
  assign rem_ge    = (rem >= LN2_V);
  assign k_sat     = (k == K_MAX);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: REDUCE ends once r < LN2 or once k cannot count any further.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)          state_nxt = REDUCE;
      REDUCE:  if (!rem_ge || k_sat)  state_nxt = DONE;
      DONE:    if (out_ready)         state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Working registers, plus the result snapshot taken on the REDUCE->DONE
  // edge. The snapshot holds while DONE waits on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem            <= '0;
      k              <= '0;
      out_k          <= '0;
      out_rem        <= '0;
      out_idx        <= '0;
      out_int_or_fra <= 1'b0;
      out_ovf        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            rem <= in_data;
            k   <= '0;
          end
        end
        REDUCE: begin
          if (rem_ge && !k_sat) begin
            rem <= rem - LN2_V;
            k   <= k + 1'b1;
          end else begin
            // Final compare: rem_ge still set here means k saturated first.
            out_k          <= k;
            out_rem        <= rem;
            out_idx        <= rem[FRAC_W-1 -: IDX_W];
            out_int_or_fra <= (k != '0);
            out_ovf        <= rem_ge;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_range_reduce.sv
// Bench for exp_range_reduce. It runs table vectors and randomized arguments
// against a division-based reference model. A second instance with K_W=3
// covers saturation.
module tb_exp_range_reduce;

  localparam int LN2 = 1419;

  typedef struct {
    int k;
    int rem;
    int idx;
    int intf;
    int ovf;
    int lat;
  } res_t;

  typedef struct {
    int   x;
    int   hold;
    res_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [14:0] in_data, out_rem;
  logic [4:0]  out_k, out_idx;
  logic        out_int_or_fra, out_ovf;

  logic        o_in_valid, o_in_ready, o_out_valid, o_out_ready;
  logic [14:0] o_in_data, o_out_rem;
  logic [2:0]  o_out_k;
  logic [4:0]  o_out_idx;
  logic        o_out_int_or_fra, o_out_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exp_range_reduce dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_k(out_k), .out_rem(out_rem), .out_idx(out_idx),
    .out_int_or_fra(out_int_or_fra), .out_ovf(out_ovf)
  );

  exp_range_reduce #(.K_W(3)) dut_ovf (
    .clk(clk), .rst_n(rst_n),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data),
    .out_valid(o_out_valid), .out_ready(o_out_ready),
    .out_k(o_out_k), .out_rem(o_out_rem), .out_idx(o_out_idx),
    .out_int_or_fra(o_out_int_or_fra), .out_ovf(o_out_ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference model: k = floor(x/LN2), saturated at kmax; r follows from k.
  function automatic res_t model(input int x, input int kmax);
    res_t r;
    int   q;
    q = x / LN2;
    if (q > kmax) q = kmax;
    r.k    = q;
    r.rem  = x - q * LN2;
    r.ovf  = (r.rem >= LN2) ? 1 : 0;
    r.idx  = (r.rem % 2048) / 64;
    r.intf = (q != 0) ? 1 : 0;
    r.lat  = q + 1;
    return r;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".in_ready"},  int'(in_ready), 1);
    chk({tag, ".out_valid"}, int'(out_valid), 0);
    chk({tag, ".out_k"},     int'(out_k), 0);
    chk({tag, ".out_rem"},   int'(out_rem), 0);
    chk({tag, ".out_idx"},   int'(out_idx), 0);
    chk({tag, ".out_int"},   int'(out_int_or_fra), 0);
    chk({tag, ".out_ovf"},   int'(out_ovf), 0);
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, ".k"},   int'(out_k), e.k);
    chk({tag, ".rem"}, int'(out_rem), e.rem);
    chk({tag, ".idx"}, int'(out_idx), e.idx);
    chk({tag, ".int"}, int'(out_int_or_fra), e.intf);
    chk({tag, ".ovf"}, int'(out_ovf), e.ovf);
  endtask

  // One operation on the main instance. The result is held for `hold`
  // cycles with out_ready low before it is released.
  task automatic run_op(input int x, input int hold, input res_t e, input string tag);
    int n;
    @(negedge clk);
    in_data   = 15'(x);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);  // t0
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 15'($urandom);
    chk({tag, ".busy"}, int'(in_ready), 0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!out_valid && n < 100);
    chk({tag, ".lat"}, n, e.lat);
    chk_res(tag, e);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 15'($urandom);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, ".hold_valid"}, int'(out_valid), 1);
      chk({tag, ".hold_rdy"},   int'(in_ready), 0);
      chk_res({tag, ".hold"}, e);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".idle_valid"}, int'(out_valid), 0);
    chk({tag, ".idle_rdy"},   int'(in_ready), 1);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    res_t e;
    vecs[0] = '{x: 1000,  hold: 0, e: '{0, 1000, 15, 0, 0, 1}};
    vecs[1] = '{x: 1419,  hold: 0, e: '{1, 0,    0,  1, 0, 2}};
    vecs[2] = '{x: 5000,  hold: 5, e: '{3, 743,  11, 1, 0, 4}};
    vecs[3] = '{x: 32767, hold: 0, e: '{23, 130, 2,  1, 0, 24}};
    vecs[4] = '{x: 0,     hold: 0, e: '{0, 0,    0,  0, 0, 1}};
    vecs[5] = '{x: 1418,  hold: 1, e: '{0, 1418, 22, 0, 0, 1}};
    vecs[6] = '{x: 2838,  hold: 0, e: '{2, 0,    0,  1, 0, 3}};

    rst_n = 1'b0;
    in_valid = 1'b0;   in_data = '0;   out_ready = 1'b1;
    o_in_valid = 1'b0; o_in_data = '0; o_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    chk("reset.ovf_rdy", int'(o_in_ready), 1);
    chk("reset.ovf_valid", int'(o_out_valid), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].x, vecs[i].hold, vecs[i].e, $sformatf("vec%0d", i));

    // Saturation on the K_W=3 instance: k pins at 7, r is left >= LN2.
    @(negedge clk);
    o_in_data = 15'd32767; o_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!o_out_valid && n < 100);
    e = model(32767, 7);
    chk("sat.lat", n, 8);
    chk("sat.k",   int'(o_out_k), 7);
    chk("sat.rem", int'(o_out_rem), 22834);
    chk("sat.idx", int'(o_out_idx), e.idx);
    chk("sat.int", int'(o_out_int_or_fra), 1);
    chk("sat.ovf", int'(o_out_ovf), 1);
    @(posedge clk);
    @(negedge clk);
    chk("sat.idle", int'(o_in_ready), 1);

    // Reset in the middle of REDUCE.
    @(negedge clk);
    in_data = 15'd32767; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst_reduce");
    rst_n = 1'b1;

    // Reset while a result sits in DONE.
    run_op(5000, 0, vecs[2].e, "pre_done_rst");
    @(negedge clk);
    in_data = 15'd3000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_done.pre_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst_done");
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Randomized arguments against the model.
    for (int i = 0; i < 40; i++) begin
      int x;
      x = int'($urandom_range(0, 32767));
      if (i % 8 == 0) x = LN2 * int'($urandom_range(0, 23));
      run_op(x, int'($urandom_range(0, 2)), model(x, 31), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
